// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the 4-channel mux scan controller.
package mux_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/mux_scan_ctrl_scan_dwell_cnt.sv
// Settle counter: counts the cycles a channel is held and flags the sample cycle.
module scan_dwell_cnt
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic             term,
    output logic [CNT_W-1:0] settle
);

    if ((SETTLE < 1) || (SETTLE > SETTLE_MAX)) begin : g_settle_range
        $error("scan_dwell_cnt: SETTLE must lie in 1..15");
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign settle = CNT_W'(SETTLE);
    assign term   = (cnt_q == CNT_W'(SETTLE - 1));

    // Next-count: wraps to zero on the sample cycle so the next channel gets a full dwell.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (enable) begin
            if (term) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequences a 4:1 gated mux through its channels and delivers the four samples
// as one word on a valid/ready port.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [SEL_W-1:0]  sel,
    output logic              g_n,
    input  logic              y,
    output logic              busy,
    output logic [NUM_CH-1:0] data,
    output logic              valid,
    input  logic              ready
);

    scan_state_t       state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              g_n_q, g_n_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [NUM_CH-1:0] data_q, data_d;
    logic [NUM_CH-1:0] cap_q, cap_d;

    logic              cnt_en_s;
    logic              cnt_term_s;
    logic [CNT_W-1:0]  settle_s;

    assign cnt_en_s = (state_q == ST_SCAN);

    scan_dwell_cnt #(
        .SETTLE (SETTLE)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (~cnt_en_s),
        .enable (cnt_en_s),
        .term   (cnt_term_s),
        .settle (settle_s)
    );

    // Next-state and next-output logic; all outputs are registered from these.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        g_n_d   = g_n_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        data_d  = data_q;
        cap_d   = cap_q;
        case (state_q)
            ST_IDLE: begin
                sel_d   = 2'd0;
                g_n_d   = 1'b1;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                if (start) begin
                    state_d = ST_SCAN;
                    g_n_d   = 1'b0;
                    busy_d  = 1'b1;
                    cap_d   = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (cnt_term_s) begin
                    cap_d[sel_q] = y;
                    if (sel_q == 2'd3) begin
                        state_d = ST_DONE;
                        data_d  = {y, cap_q[2:0]};
                        valid_d = 1'b1;
                        g_n_d   = 1'b1;
                        busy_d  = 1'b0;
                        sel_d   = 2'd0;
                    end else begin
                        sel_d = sel_q + 2'd1;
                    end
                end else begin
                    sel_d = sel_q;
                end
            end
            ST_DONE: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    if (start) begin
                        // Handshake and new request together: re-enter SCAN with no IDLE gap.
                        state_d = ST_SCAN;
                        sel_d   = 2'd0;
                        g_n_d   = 1'b0;
                        busy_d  = 1'b1;
                        cap_d   = 4'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 2'd0;
                g_n_d   = 1'b1;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= 2'd0;
            g_n_q   <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 4'd0;
            cap_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            g_n_q   <= g_n_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
        end
    end

    assign sel   = sel_q;
    assign g_n   = g_n_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign data  = data_q;

endmodule
